// File: rtl/sm_stream_conv_if.sv
// Handshake bundle for sm_stream_conv: input stream (two's complement words)
// and output stream (sign-magnitude words with overflow qualifier).
interface sm_stream_conv_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    // Converter side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );
endinterface

// File: rtl/sm_stream_conv.sv
// Streaming two's-complement to sign-magnitude converter.
// Two registered stages: S1 holds the raw input word, S2 holds the converted
// word, its overflow flag and the output valid. The most negative input has no
// sign-magnitude encoding; it saturates to all ones and raises out_ovf.
// A saturating counter tracks how many overflow words were transferred out.
module sm_stream_conv #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    sm_stream_conv_if.slave  bus
);

    logic             r_s1_valid;
    logic [W-1:0]     r_s1_data;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_data;
    logic             r_s2_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [W-2:0]     w_neg_mag;
    logic [W-1:0]     w_conv_data;
    logic             w_conv_ovf;
    logic             w_cnt_inc;

    // S2 can take a word when empty or when its word leaves this cycle.
    assign w_s2_load  = !r_s2_valid || bus.out_ready;
    // S1 can take a word when empty or when its word moves into S2.
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = bus.in_valid && w_s1_load;
    assign w_out_xfer = r_s2_valid && bus.out_ready;

    // Magnitude bits of a negative word: low bits of (~a + 1). The carry out
    // of the low field only affects the sign bit, which is not needed here.
    assign w_neg_mag = ~r_s1_data[W-2:0] + (W-1)'(1);

    assign w_cnt_inc = w_out_xfer && r_s2_ovf && (r_cnt != '1);

    // Conversion of the S1 word to sign-magnitude with overflow detection.
    always_comb begin
        w_conv_data = r_s1_data;
        w_conv_ovf  = 1'b0;
        if (r_s1_data[W-1]) begin
            if (r_s1_data[W-2:0] == '0) begin
                w_conv_data = '1;
                w_conv_ovf  = 1'b1;
            end else begin
                w_conv_data = {1'b1, w_neg_mag};
            end
        end
    end

    // Stage 1: capture the raw input word whenever the stage may load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (w_in_xfer) begin
                r_s1_data <= bus.in_data;
            end
        end
    end

    // Stage 2: register the converted word; holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_conv_data;
                r_s2_ovf  <= w_conv_ovf;
            end
        end
    end

    // Saturating overflow event counter; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_ovf   = r_s2_ovf;
    assign ovf_cnt       = r_cnt;

endmodule

// File: tb/tb_sm_stream_conv.sv
// Self-checking bench for sm_stream_conv (W=8, CNT_W=2): directed cases,
// exhaustive sweep, backpressure, counter saturation/clear, random traffic
// and mid-stream reset, all checked against a queue-based reference model.
module tb_sm_stream_conv;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             clr_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    sm_stream_conv_if #(.W(W)) bus ();

    sm_stream_conv #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_cnt (clr_cnt),
        .ovf_cnt (ovf_cnt),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference conversion from signed arithmetic: {ovf, sign-magnitude word}.
    function automatic logic [8:0] conv_ref(input logic [7:0] a);
        int v;
        int mag;
        logic [7:0] r;
        v = int'($signed(a));
        if (v == -128) return {1'b1, 8'hFF};
        mag = (v < 0) ? -v : v;
        r = 8'(mag);
        if (v < 0) r[7] = 1'b1;
        return {1'b0, r};
    endfunction

    // Reference model state: words in flight (expected results) and counter.
    logic [8:0]  q[$];
    int unsigned mcnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;

    // Monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            q.delete();
            mcnt      = 0;
            prev_hold = 1'b0;
        end else begin
            chk("ovf_cnt", 32'(ovf_cnt), mcnt);
            chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && q.size() == 0)
                chk("spurious_valid", 32'(bus.out_valid), 0);
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
                chk("out_ovf", 32'(bus.out_ovf), 32'(e[8]));
                if (!clr_cnt && e[8] && mcnt < CMAX) mcnt = mcnt + 1;
            end
            if (clr_cnt) mcnt = 0;
            if (bus.in_valid && bus.in_ready) q.push_back(conv_ref(bus.in_data));
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr_cnt       = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic clr_pulse();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    // Single word on an empty pipeline with out_ready=1; checks latency.
    task automatic send_one(input logic [7:0] d, input logic [7:0] ed, input logic eo,
                            input logic chk_cnt, input logic [CNT_W-1:0] cnt_after);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();                     // accepted at this edge
        bus.in_valid = 1'b0;
        chk("lat_early", 32'(bus.out_valid), 0);
        step();
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("single_data", 32'(bus.out_data), 32'(ed));
        chk("single_ovf", 32'(bus.out_ovf), 32'(eo));
        if (chk_cnt) chk("cnt_before", 32'(ovf_cnt), 0);
        step();                     // transferred out at this edge
        chk("single_gone", 32'(bus.out_valid), 0);
        if (chk_cnt) chk("cnt_after", 32'(ovf_cnt), 32'(cnt_after));
    endtask

    logic [7:0] sd [6] = '{8'h05, 8'hFB, 8'hFF, 8'h81, 8'h00, 8'h80};
    logic [7:0] se [6] = '{8'h05, 8'h85, 8'h81, 8'hFF, 8'h00, 8'hFF};
    logic       so [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int unsigned acc_n;
        logic        acc;

        rst_n         = 1'b1;
        clr_cnt       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
        #30 rst_n = 1'b1;           // release between edges
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 1);

        // Directed single words, including the overflow case
        for (int i = 0; i < 6; i++) send_one(sd[i], se[i], so[i], so[i], 1);

        // Exhaustive back-to-back sweep
        clr_pulse();
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            chk("sweep_ready", 32'(bus.in_ready), 1);
            step();
        end
        drain();
        step();
        chk("sweep_cnt", 32'(ovf_cnt), 1);

        // Backpressure: only two words fit while out_ready=0
        bus.out_ready = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + acc_n);
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) acc_n++;
        end
        chk("bp_accepted", acc_n, 2);
        chk("bp_ready_low", 32'(bus.in_ready), 0);
        chk("bp_valid", 32'(bus.out_valid), 1);
        chk("bp_hold_data", 32'(bus.out_data), 32'h10);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_seq1_valid", 32'(bus.out_valid), 1);
        chk("bp_seq1_data", 32'(bus.out_data), 32'h11);
        step();
        chk("bp_seq2_valid", 32'(bus.out_valid), 1);
        chk("bp_seq2_data", 32'(bus.out_data), 32'h12);
        drain();

        // Counter saturation
        clr_pulse();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h80;
            step();
        end
        drain();
        step();
        chk("cnt_saturate", 32'(ovf_cnt), CMAX);

        // Clear coinciding with an overflow transfer (once from 3, once from 0)
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h80;
            step();
            bus.in_valid = 1'b0;
            step();
            chk("clr_xfer_valid", 32'(bus.out_valid), 1);
            clr_cnt = 1'b1;
            step();
            clr_cnt = 1'b0;
            chk("clr_wins", 32'(ovf_cnt), 0);
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_data   = (($urandom % 5) == 0) ? 8'h80 : 8'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            clr_cnt       = ($urandom % 40) == 0;
            step();
        end
        drain();

        // Mid-stream asynchronous reset with two words buffered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h33;
        step();
        bus.in_data   = 8'h44;
        step();
        bus.in_valid  = 1'b0;
        chk("mid_full_ready", 32'(bus.in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_data", 32'(bus.out_data), 0);
        chk("mid_rst_cnt", 32'(ovf_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("no_stale", 32'(bus.out_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
